load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RV32I datapath. It takes the ALU result as the effective address plus rs2 data and funct3 for loads and stores. It drives a word-addressed data-memory port with byte enables and a req/ready handshake, then returns the load result aligned and sign- or zero-extended for writeback. It reports misaligned or illegal accesses instead of issuing them.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin an access; sampled only in IDLE
is_store  input  1  1 = store (SB/SH/SW), 0 = load
funct3  input  3  RV32I load/store funct3
addr  input  XLEN  effective address (ALU output)
wdata  input  XLEN  store data (rs2)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when an access completes or faults
fault  output  1  valid with done; 1 = misaligned or illegal funct3
rdata  output  XLEN  extended load result, valid from the done cycle until the next done
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  XLEN  word address, addr with bits [1:0] forced to 0
mem_wdata  output  XLEN  lane-replicated store data
mem_be  output  4  byte enables
mem_ready  input  1  memory accepts the request (store) or has valid mem_rdata (load) this cycle
mem_rdata  input  XLEN  read word

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0 (busy, done, fault, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be). The effect is immediate and not clock-dependent, including mid-transaction.
- FSM has four states: IDLE, REQ, DONE, FAULT. All outputs are registered.
- IDLE, start=1 at edge T:
  - Latch is_store, funct3, addr[1:0] and the computed memory outputs.
  - If the access is legal: go to REQ; mem_req=1 from T.
  - Otherwise: go to FAULT; mem_req stays 0.
- start while busy is ignored; no queuing.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ready.
  - On an edge with mem_ready=1: capture/extract load data into rdata (store: rdata=0), drop mem_req, go to DONE.
  - There is no timeout.
- DONE: done=1, fault=0 for exactly one cycle, then IDLE.
- FAULT: done=1, fault=1, rdata=0 for one cycle, then IDLE.
- Minimum latency: start at edge T, mem_ready high at T+1, done high in the cycle following edge T+1. Each wait cycle of mem_ready adds one cycle.
- Legality:
  - funct3 in {000, 001, 010, 100, 101} is legal for loads.
  - funct3 in {000, 001, 010} is legal for stores.
  - Any other funct3 is illegal.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
- Store lanes:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads:
  - mem_we=0; mem_be per the same lane rule.
  - Selected byte/half taken from mem_rdata by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- done and mem_req are never high in the same cycle.
- busy=1 from the edge that accepts start through the DONE/FAULT cycle inclusive.

Test Plan:
- LB, addr=0x103, mem_rdata=0x80FF1234, mem_ready=1 next cycle -> mem_addr=0x100, mem_be=1000, done one cycle later, rdata=0xFFFFFF80, fault=0.
- LHU, addr=0x202, mem_rdata=0xBEEF0000 -> mem_be=1100, rdata=0x0000BEEF; LH at the same address gives 0xFFFFBEEF.
- SB, addr=0x101, wdata=0x123456AB, mem_ready delayed 3 cycles -> mem_req/mem_we=1, mem_be=0010, mem_wdata=0xABABABAB held stable for 4 cycles, done pulses once, rdata=0.
- LW at addr=0x102, and SH with funct3=001 at addr=0x301 -> mem_req never asserts; done=1, fault=1 one cycle after start; busy for exactly 1 cycle.
- Load with funct3=011 -> fault. Store with funct3=100 -> fault.
- Assert rst while in REQ with mem_ready=0 -> mem_req and busy drop without a clock edge. A new start after reset completes normally. start pulses during busy produce no extra done.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the pipeline-side request/response signals and the data-memory port
// of the load/store unit. The unit connects through the slave modport; the
// pipeline and memory together form the master side.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  // Pipeline side
  logic            start;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            fault;
  logic [XLEN-1:0] rdata;

  // Data-memory side
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
    input  busy, done, fault, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
    output busy, done, fault, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage. Takes the ALU result as effective address, checks
// alignment and funct3 legality, drives a word-addressed memory port with byte
// enables and a req/ready handshake, and returns the extended load result.
// Illegal or misaligned accesses are reported as a fault and never issued.
// All outputs are registered; only XLEN = 32 is supported.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  load_store_unit_if.slave       bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]      state;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;

  logic            busy_q;
  logic            done_q;
  logic            fault_q;
  logic [XLEN-1:0] rdata_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_be_q;

  logic            legal;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;

  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_ext;

  // Decode legality, byte lanes and replicated store data for the incoming request
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    legal      = 1'b0;
    be_next    = 4'b0000;
    wdata_next = '0;
    case (bus.funct3)
      3'b000: begin // LB / SB
        legal      = 1'b1;
        be_next    = 4'b0001 << bus.addr[1:0];
        wdata_next = {4{bus.wdata[7:0]}};
      end
      3'b001: begin // LH / SH
        legal      = ~bus.addr[0];
        be_next    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.wdata[15:0]}};
      end
      3'b010: begin // LW / SW
        legal      = (bus.addr[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = bus.wdata;
      end
      3'b100: begin // LBU only
        legal      = ~bus.is_store;
        be_next    = 4'b0001 << bus.addr[1:0];
      end
      3'b101: begin // LHU only
        legal      = ~bus.is_store & ~bus.addr[0];
        be_next    = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: legal = 1'b0;
    endcase
    // Loads never present write data on the bus
    if (!bus.is_store) wdata_next = '0;
  end

  // Select the addressed byte/halfword of the returned word and extend it
  always_comb begin
    lane_byte = 8'h00;
    lane_half = 16'h0000;
    load_ext  = '0;
    case (addr_lo_q)
      2'd0:    lane_byte = bus.mem_rdata[7:0];
      2'd1:    lane_byte = bus.mem_rdata[15:8];
      2'd2:    lane_byte = bus.mem_rdata[23:16];
      default: lane_byte = bus.mem_rdata[31:24];
    endcase
    lane_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b010:  load_ext = bus.mem_rdata;
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane_byte};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane_half};
      default: load_ext = '0;
    endcase
  end

  // Access sequencer: accept, issue and hold the request, then pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_store_q  <= bus.is_store;
            funct3_q    <= bus.funct3;
            addr_lo_q   <= bus.addr[1:0];
            mem_addr_q  <= {bus.addr[XLEN-1:2], 2'b00};
            mem_be_q    <= be_next;
            mem_wdata_q <= wdata_next;
            busy_q      <= 1'b1;
            if (legal) begin
              state     <= S_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= bus.is_store;
            end else begin
              state   <= S_FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_REQ: begin
          // Request fields stay frozen until memory accepts or returns data
          if (bus.mem_ready) begin
            rdata_q   <= is_store_q ? '0 : load_ext;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin // S_DONE, S_FAULT: single completion cycle
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule
